if_queue: RTL and testbench

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/if_queue_pkg.sv | 19 +
 rtl/ifq_ram.sv | 36 +++
 rtl/if_queue.sv | 104 ++++++++++
 tb/tb_if_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/if_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the datapath widths, the NOP encoding driven when the queue is
// empty, the default depth, and the packed pc/inst entry that the storage
// array holds.
package if_queue_pkg;

  localparam int ADDR_W        = 32;
  localparam int INST_W        = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000000;
  localparam int IFQ_DEPTH_DEF = 4;
  localparam int ENTRY_W       = ADDR_W + INST_W;

  // One queued instruction: fetch address plus instruction word.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Storage array for the fetch queue.
// DEPTH x 64-bit, one synchronous write port and one asynchronous
// (combinational) read port. Contents are never reset; the owner decides
// which entries are visible.
//
// Ports:
//   clk      in   write clock
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   entry to store
//   i_raddr  in   read index
//   o_rdata  out  entry at i_raddr (combinational)
module ifq_ram
  import if_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  ifq_entry_t               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output ifq_entry_t               o_rdata
);

  ifq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between fetch and decode.
// A DEPTH-entry circular buffer of pc/inst pairs. Pointer and occupancy
// control lives here; the pairs themselves sit in ifq_ram.
//
// Handshake: an offer transfers on a rising edge when valid and ready are
// both high in that cycle; valid never depends on ready on the same side.
// in_ready is derived only from occupancy (and reset), so a full queue
// refuses an offer even if decode pops in that cycle. flush overrides both
// transfers and empties the queue on the next edge.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   drop all entries (redirect)
//   in_valid   in   fetch offers in_pc/in_inst
//   in_pc      in   offered address
//   in_inst    in   offered instruction
//   in_ready   out  queue accepts the offer
//   out_valid  out  head entry available
//   out_pc     out  head address (0 when empty)
//   out_inst   out  head instruction (NOP when empty)
//   out_ready  in   decode consumes the head
//   count      out  current occupancy
module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [INST_W-1:0]      in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INST_W-1:0]      out_inst,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic       w_push;
  logic       w_pop;
  ifq_entry_t w_wr_entry;
  ifq_entry_t w_rd_entry;

  assign in_ready  = (r_count < FULL_CNT) && !rst;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_wr_entry = '{pc: in_pc, inst: in_inst};

  ifq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wr_entry),
    .i_raddr (r_head),
    .o_rdata (w_rd_entry)
  );

  // Stale array contents are masked by occupancy; an empty queue shows a NOP.
  assign out_pc   = out_valid ? w_rd_entry.pc   : '0;
  assign out_inst = out_valid ? w_rd_entry.inst : NOP_INST;
  assign count    = r_count;

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_ready;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  if_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  // ---------------- scoreboard state ----------------
  // exp_q is the reference queue: {pc, inst} in acceptance order.
  logic [63:0] exp_q[$];
  logic        cyc_push;   // driver appended to exp_q in the current cycle
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge. An offer is accepted
  // when the reference queue has room, there is no flush and no reset.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    cyc_push  = v && !fl && !rst && (exp_q.size() < DEPTH);
    if (cyc_push) exp_q.push_back({pc, inst});
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    idle();
    @(negedge clk);
    check("drain_count", 64'(count), 64'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int occ;
    if (rst) begin
      check("rst_count",     64'(count),     64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(0));
      check("rst_out_pc",    64'(out_pc),    64'(0));
      check("rst_out_inst",  64'(out_inst),  64'(0));
    end else begin
      occ = exp_q.size() - (cyc_push ? 1 : 0);
      check("count",     64'(count),     64'(occ));
      check("in_ready",  64'(in_ready),  64'(occ < DEPTH));
      check("out_valid", 64'(out_valid), 64'(occ != 0));
      if (occ != 0) begin
        check("head_pc",   64'(out_pc),   64'(exp_q[0][63:32]));
        check("head_inst", 64'(out_inst), 64'(exp_q[0][31:0]));
      end else begin
        check("empty_pc",   64'(out_pc),   64'(0));
        check("empty_inst", 64'(out_inst), 64'(0));
      end
      if (flush) begin
        exp_q.delete();
      end else if (out_ready && occ != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;
    cyc_push  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Three pushes while decode stalls.
    drive(1'b1, 32'h0, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 32'h33, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t1_count", 64'(count),    64'(3));
    check("t1_pc",    64'(out_pc),   64'(32'h0));
    check("t1_inst",  64'(out_inst), 64'(32'h11));

    // Fill to DEPTH; a fifth offer is refused; drain order checked by monitor.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h10, 32'hBAD, 1'b0, 1'b0);
    @(negedge clk);
    check("full_count",    64'(count),    64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    drain();

    // Push and pop together at count=2.
    drive(1'b1, 32'h200, 32'hA0, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 32'h208, 32'hA2, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("pp_count", 64'(count),  64'(2));
    check("pp_pc",    64'(out_pc), 64'(32'h204));
    drain();

    // Ten continuous push/pop cycles wrap both pointers.
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(4 * i), 32'h300 + 32'(i), 1'b1, 1'b0);
    drain();

    // Flush with a same-cycle offer.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hBAD0, 32'hDEAD, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("fl_count",     64'(count),     64'(0));
    check("fl_out_valid", 64'(out_valid), 64'(0));
    check("fl_out_inst",  64'(out_inst),  64'(0));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries queued.
    drive(1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 32'h51, 1'b0, 1'b0);
    idle();
    #2;
    rst      = 1'b1;
    cyc_push = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count",     64'(count),     64'(0));
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_in_ready",  64'(in_ready),  64'(0));
    check("arst_out_pc",    64'(out_pc),    64'(0));
    check("arst_out_inst",  64'(out_inst),  64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h100, 32'h77, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("post_rst_pc",   64'(out_pc),   64'(32'h100));
    check("post_rst_inst", 64'(out_inst), 64'(32'h77));
    drain();

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom() & 32'hFFFF_FFFC,
            $urandom(),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    end
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
